pcie_pipe_lane_deskew: RTL and testbench

//  Parametrised multi-lane PIPE receive deskew buffer for the PCIe HIP PIPE simulation path.
//  It sits between the per-lane hip_pipe_rxdata*/rxdatak*/rxvalid*/rxelecidle* signals and the lane consumer.

---
 rtl/pcie_pipe_lane_deskew.sv | 250 +++++++++++++++++++++++++
 tb/tb_pcie_pipe_lane_deskew.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_pipe_lane_deskew.sv
// Multi-lane PIPE receive deskew buffer.
// Each active lane feeds a small FIFO; a three-state FSM (IDLE/SEARCH/ALIGNED)
// lines the lanes up on a COM K-symbol and then emits lane-aligned columns.

// Per-lane FIFO: write visible at the head next cycle, flush has priority.
module pcie_pipe_lane_deskew_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       wr_i,
    input  logic [7:0] wdata_i,
    input  logic       wdatak_i,
    input  logic       pop_i,
    input  logic       flush_i,
    output logic [7:0] head_d_o,
    output logic       head_k_o,
    output logic       empty_o,
    output logic       full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [8:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        do_wr, do_pop;

    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop frees the slot being written, so write+pop on a full FIFO is legal.
    assign do_wr    = wr_i && (!full_o || pop_i);
    assign do_pop   = pop_i && !empty_o;
    assign head_d_o = mem_q[rd_ptr_q[AW-1:0]][7:0];
    assign head_k_o = mem_q[rd_ptr_q[AW-1:0]][8];

    // Pointer update; flush empties the FIFO and drops any same-cycle write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array; contents beyond the pointers are don't-care.
    always_ff @(posedge clk_i) begin
        if (do_wr && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= {wdatak_i, wdata_i};
    end
endmodule

module pcie_pipe_lane_deskew #(
    parameter int         LANES    = 8,
    parameter int         DEPTH    = 8,
    parameter int         MAX_SKEW = 4,
    parameter logic [7:0] COM_SYM  = 8'hBC
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               enable,
    input  logic [4:0]         lane_cnt,
    input  logic [LANES*8-1:0] rx_data,
    input  logic [LANES-1:0]   rx_datak,
    input  logic [LANES-1:0]   rx_valid,
    input  logic [LANES-1:0]   rx_elecidle,
    output logic [LANES*8-1:0] out_data,
    output logic [LANES-1:0]   out_datak,
    output logic               out_valid,
    output logic               aligned,
    output logic               deskew_err,
    output logic [7:0]         err_count,
    output logic               overflow
);
    localparam int SW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_ALIGNED} state_t;

    state_t               state_q, state_d;
    logic [4:0]           lane_cnt_q, lane_cnt_d, cnt_sel;
    logic [SW-1:0]        skew_q, skew_d;
    logic                 ovf_q, ovf_d;
    logic                 out_vld_q, out_vld_d;
    logic [LANES*8-1:0]   out_data_q, out_data_d;
    logic [LANES-1:0]     out_datak_q, out_datak_d;
    logic                 aligned_q, deskew_err_q;
    logic [7:0]           err_cnt_q, err_cnt_d;

    logic [LANES-1:0][7:0] head_d;
    logic [LANES-1:0]      head_k, empty, full;
    logic [LANES-1:0]      act, is_com, wr_vec, pop, flush;
    logic                  all_ne, all_com, some_com, any_eidle, ovf_ev, err_ev, load;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            pcie_pipe_lane_deskew_fifo #(.DEPTH(DEPTH)) u_fifo (
                .clk_i    (clk_clk),
                .rst_ni   (reset_reset_n),
                .wr_i     (wr_vec[g]),
                .wdata_i  (rx_data[g*8 +: 8]),
                .wdatak_i (rx_datak[g]),
                .pop_i    (pop[g]),
                .flush_i  (flush[g]),
                .head_d_o (head_d[g]),
                .head_k_o (head_k[g]),
                .empty_o  (empty[g]),
                .full_o   (full[g])
            );
        end
    endgenerate

    // Active-lane mask: live lane_cnt while IDLE, latched value otherwise.
    always_comb begin
        cnt_sel = (state_q == ST_IDLE) ? lane_cnt : lane_cnt_q;
        for (int i = 0; i < LANES; i++) begin
            act[i]    = (cnt_sel == 5'd0 || 32'(cnt_sel) > LANES) ? 1'b1 : (i < 32'(cnt_sel));
            is_com[i] = act[i] && !empty[i] && head_k[i] && (head_d[i] == COM_SYM);
        end
    end

    assign all_ne    = &(~empty | ~act);
    assign all_com   = &(is_com | ~act);
    assign some_com  = |is_com;
    assign any_eidle = |(rx_elecidle & act);
    assign wr_vec    = rx_valid & act & {LANES{state_q != ST_IDLE}};
    assign ovf_ev    = |(wr_vec & full & ~pop);

    // Pop selection: SEARCH discards non-COM heads, ALIGNED pops whole columns.
    always_comb begin
        pop = '0;
        if (state_q == ST_SEARCH)
            pop = all_com ? act : (act & ~empty & ~is_com);
        else if (state_q == ST_ALIGNED && all_ne)
            pop = act;
    end

    // Next-state logic, prioritised enable > elecidle > overflow > skew/misalign.
    always_comb begin
        state_d     = state_q;
        lane_cnt_d  = lane_cnt_q;
        skew_d      = skew_q;
        ovf_d       = ovf_q;
        flush       = ~act;
        err_ev      = 1'b0;
        load        = 1'b0;
        out_vld_d   = 1'b0;
        out_data_d  = out_data_q;
        out_datak_d = out_datak_q;
        if (!enable) begin
            state_d     = ST_IDLE;
            flush       = '1;
            ovf_d       = 1'b0;
            skew_d      = '0;
            out_data_d  = '0;
            out_datak_d = '0;
        end else if (state_q == ST_IDLE) begin
            flush       = '1;
            skew_d      = '0;
            out_data_d  = '0;
            out_datak_d = '0;
            if (!any_eidle) begin
                state_d    = ST_SEARCH;
                lane_cnt_d = lane_cnt;
            end
        end else if (any_eidle) begin
            state_d = ST_IDLE;
            flush   = '1;
            skew_d  = '0;
        end else if (ovf_ev) begin
            state_d = ST_SEARCH;
            flush   = '1;
            ovf_d   = 1'b1;
            skew_d  = '0;
            err_ev  = (state_q == ST_ALIGNED);
        end else if (state_q == ST_SEARCH) begin
            if (all_com) begin
                state_d = ST_ALIGNED;
                skew_d  = '0;
                load    = 1'b1;
            end else if (some_com) begin
                // Counter value MAX_SKEW-1 here means this is the MAX_SKEW-th partial cycle.
                if (skew_q == SW'(MAX_SKEW - 1)) begin
                    err_ev = 1'b1;
                    flush  = '1;
                    skew_d = '0;
                end else begin
                    skew_d = skew_q + 1'b1;
                end
            end else begin
                skew_d = '0;
            end
        end else if (all_ne) begin
            if (some_com && !all_com) begin
                err_ev  = 1'b1;
                flush   = '1;
                state_d = ST_SEARCH;
                skew_d  = '0;
            end else begin
                load = 1'b1;
            end
        end
        if (load) begin
            out_vld_d = 1'b1;
            for (int i = 0; i < LANES; i++) begin
                out_data_d[i*8 +: 8] = act[i] ? head_d[i] : 8'h00;
                out_datak_d[i]       = act[i] & head_k[i];
            end
        end
        err_cnt_d = err_cnt_q + 8'((err_ev && err_cnt_q != 8'hFF) ? 1 : 0);
    end

    // State and registered outputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= ST_IDLE;
            lane_cnt_q   <= '0;
            skew_q       <= '0;
            ovf_q        <= 1'b0;
            out_vld_q    <= 1'b0;
            out_data_q   <= '0;
            out_datak_q  <= '0;
            aligned_q    <= 1'b0;
            deskew_err_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            lane_cnt_q   <= lane_cnt_d;
            skew_q       <= skew_d;
            ovf_q        <= ovf_d;
            out_vld_q    <= out_vld_d;
            out_data_q   <= out_data_d;
            out_datak_q  <= out_datak_d;
            aligned_q    <= (state_d == ST_ALIGNED);
            deskew_err_q <= err_ev;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_datak  = out_datak_q;
    assign out_valid  = out_vld_q;
    assign aligned    = aligned_q;
    assign deskew_err = deskew_err_q;
    assign err_count  = err_cnt_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_pcie_pipe_lane_deskew.sv
// Directed bench for pcie_pipe_lane_deskew (LANES=8, DEPTH=8, MAX_SKEW=4).
module tb_pcie_pipe_lane_deskew;
    localparam int LANES = 8;
    localparam int DEPTH = 8;
    localparam int MAX_SKEW = 4;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [4:0]  lane_cnt = '0;
    logic [63:0] rx_data = '0;
    logic [7:0]  rx_datak = '0, rx_valid = '0, rx_elecidle = '0;
    logic [63:0] out_data;
    logic [7:0]  out_datak;
    logic        out_valid, aligned, deskew_err, overflow;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;
    int dly [8];
    int ncol, npulse, first_err, first_al;

    always #5 clk_clk = ~clk_clk;

    pcie_pipe_lane_deskew #(.LANES(LANES), .DEPTH(DEPTH), .MAX_SKEW(MAX_SKEW), .COM_SYM(8'hBC)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable), .lane_cnt(lane_cnt),
        .rx_data(rx_data), .rx_datak(rx_datak), .rx_valid(rx_valid), .rx_elecidle(rx_elecidle),
        .out_data(out_data), .out_datak(out_datak), .out_valid(out_valid), .aligned(aligned),
        .deskew_err(deskew_err), .err_count(err_count), .overflow(overflow)
    );

    typedef struct {
        logic       en;
        logic [7:0] vld;
        logic [7:0] sym;
        logic       k;
        logic       ev;
        logic [7:0] ed;
        logic       ek;
        logic       ea;
        logic       eer;
    } vec_t;
    vec_t tv [9];

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        enable = 1'b0; lane_cnt = '0;
        rx_valid = '0; rx_data = '0; rx_datak = '0; rx_elecidle = '0;
        #2;
        reset_reset_n = 1'b1;
    endtask

    function automatic logic [8:0] sym(input int p, input int per);
        if (p % per == 0) return {1'b1, 8'hBC};
        return {1'b0, 8'(p)};
    endfunction

    // Each active lane plays stream position (t - dly[lane]); inactive lanes get noise.
    task automatic run_stream(input int per, input int len, input int ncyc, input logic [4:0] lc, input bit cols);
        int lce;
        logic [63:0] ed;
        logic [7:0]  ek;
        logic [8:0]  s;
        lce = (lc == 0 || lc > 8) ? 8 : int'(lc);
        do_reset();
        enable = 1'b1; lane_cnt = lc;
        step();
        ncol = 0; npulse = 0; first_err = -1; first_al = -1;
        for (int t = 0; t < ncyc; t++) begin
            for (int l = 0; l < 8; l++) begin
                int p;
                p = t - dly[l];
                if (l >= lce) begin
                    rx_valid[l] = 1'($urandom);
                    rx_datak[l] = 1'($urandom);
                    rx_elecidle[l] = 1'($urandom);
                    rx_data[l*8 +: 8] = 8'($urandom);
                end else if (p >= 0 && p < len) begin
                    s = sym(p, per);
                    rx_valid[l] = 1'b1; rx_datak[l] = s[8]; rx_data[l*8 +: 8] = s[7:0];
                    rx_elecidle[l] = 1'b0;
                end else begin
                    rx_valid[l] = 1'b0; rx_datak[l] = 1'b0; rx_data[l*8 +: 8] = 8'h00;
                    rx_elecidle[l] = 1'b0;
                end
            end
            step();
            if (deskew_err) begin
                npulse++;
                if (first_err < 0) first_err = t;
            end
            if (aligned && first_al < 0) first_al = t;
            if (out_valid) begin
                if (cols) begin
                    s = sym(ncol, per);
                    for (int l = 0; l < 8; l++) begin
                        ed[l*8 +: 8] = (l < lce) ? s[7:0] : 8'h00;
                        ek[l] = (l < lce) ? s[8] : 1'b0;
                    end
                    chk($sformatf("col%0d data", ncol), out_data, ed);
                    chk($sformatf("col%0d datak", ncol), 64'(out_datak), 64'(ek));
                end
                ncol++;
            end
        end
        rx_valid = '0; rx_elecidle = '0;
    endtask

    initial begin
        // ---- Test 1: all lanes aligned, table-driven cycle by cycle ----
        tv[0] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tv[2] = '{1'b1, 8'hFF, 8'hBC, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tv[3] = '{1'b1, 8'hFF, 8'h10, 1'b0, 1'b1, 8'hBC, 1'b1, 1'b1, 1'b0};
        tv[4] = '{1'b1, 8'hFF, 8'h11, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0};
        tv[5] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0};
        tv[6] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0};
        tv[7] = '{1'b1, 8'hFF, 8'hBC, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0};
        tv[8] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'hBC, 1'b1, 1'b1, 1'b0};
        do_reset();
        lane_cnt = 5'd8;
        for (int j = 0; j < 9; j++) begin
            enable = tv[j].en; rx_valid = tv[j].vld;
            rx_data = {8{tv[j].sym}}; rx_datak = {8{tv[j].k}};
            step();
            chk($sformatf("r%0d out_valid", j), 64'(out_valid), 64'(tv[j].ev));
            chk($sformatf("r%0d aligned", j), 64'(aligned), 64'(tv[j].ea));
            chk($sformatf("r%0d deskew_err", j), 64'(deskew_err), 64'(tv[j].eer));
            chk($sformatf("r%0d out_data", j), out_data, {8{tv[j].ed}});
            chk($sformatf("r%0d out_datak", j), 64'(out_datak), 64'({8{tv[j].ek}}));
            chk($sformatf("r%0d err_count", j), 64'(err_count), 64'd0);
            chk($sformatf("r%0d overflow", j), 64'(overflow), 64'd0);
        end

        // ---- Test 5: COM on lane 0 only while ALIGNED ----
        rx_valid = 8'hFF; rx_data = {{7{8'h55}}, 8'hBC}; rx_datak = 8'h01;
        step();
        chk("t5 no pop yet", 64'(out_valid), 64'd0);
        rx_valid = '0;
        step();
        chk("t5 deskew_err", 64'(deskew_err), 64'd1);
        chk("t5 suppressed", 64'(out_valid), 64'd0);
        chk("t5 aligned drop", 64'(aligned), 64'd0);
        chk("t5 err_count", 64'(err_count), 64'd1);
        chk("t5 data held", out_data, {8{8'hBC}});
        step();
        chk("t5 pulse width", 64'(deskew_err), 64'd0);
        rx_valid = 8'hFF; rx_data = {8{8'hBC}}; rx_datak = 8'hFF;
        step();
        rx_valid = '0;
        step();
        chk("t5 realign", 64'(aligned), 64'd1);
        chk("t5 realign col", 64'(out_valid), 64'd1);

        // ---- Test 6: lane 1 starved, others overflow ----
        for (int j = 0; j <= DEPTH; j++) begin
            rx_valid = 8'hFD; rx_data = {8{8'(8'h20 + j)}}; rx_datak = '0;
            step();
            if (j == DEPTH - 1) begin
                chk("t6 full no ovf", 64'(overflow), 64'd0);
                chk("t6 still aligned", 64'(aligned), 64'd1);
            end
        end
        chk("t6 overflow", 64'(overflow), 64'd1);
        chk("t6 ovf err pulse", 64'(deskew_err), 64'd1);
        chk("t6 ovf leaves aligned", 64'(aligned), 64'd0);
        chk("t6 err_count", 64'(err_count), 64'd2);
        rx_valid = '0;
        step();
        chk("t6 overflow sticky", 64'(overflow), 64'd1);
        chk("t6 pulse over", 64'(deskew_err), 64'd0);
        rx_elecidle = 8'h01;
        step();
        chk("t6 eidle aligned", 64'(aligned), 64'd0);
        chk("t6 eidle keeps ovf", 64'(overflow), 64'd1);
        rx_elecidle = '0; enable = 1'b0;
        step();
        chk("t6 enable clears ovf", 64'(overflow), 64'd0);
        chk("t6 err_count kept", 64'(err_count), 64'd2);

        // ---- Reset asserted mid-ALIGNED ----
        enable = 1'b1;
        step();
        rx_valid = 8'hFF; rx_data = {8{8'hBC}}; rx_datak = 8'hFF;
        step();
        rx_valid = '0;
        step();
        chk("rst pre aligned", 64'(aligned), 64'd1);
        chk("rst pre valid", 64'(out_valid), 64'd1);
        reset_reset_n = 1'b0;
        #2;
        chk("rst aligned", 64'(aligned), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", out_data, 64'd0);
        chk("rst out_datak", 64'(out_datak), 64'd0);
        chk("rst err_count", 64'(err_count), 64'd0);

        // ---- Test 2: lane 3 three cycles late, within skew limit ----
        dly = '{0, 0, 0, 3, 0, 0, 0, 0};
        run_stream(100, 12, 20, 5'd8, 1'b1);
        chk("t2 columns", 64'(ncol), 64'd12);
        chk("t2 no err", 64'(npulse), 64'd0);
        chk("t2 aligned at", 64'(first_al), 64'd4);
        chk("t2 err_count", 64'(err_count), 64'd0);

        // ---- Skew boundary: lane 3 four cycles late ----
        dly = '{0, 0, 0, 4, 0, 0, 0, 0};
        run_stream(100, 12, 12, 5'd8, 1'b0);
        chk("skew4 err at", 64'(first_err), 64'd4);
        chk("skew4 pulses", 64'(npulse), 64'd1);
        chk("skew4 columns", 64'(ncol), 64'd0);
        chk("skew4 err_count", 64'(err_count), 64'd1);

        // ---- Test 3: lane 5 six cycles late, COM every 6 symbols ----
        dly = '{0, 0, 0, 0, 0, 6, 0, 0};
        run_stream(6, 24, 32, 5'd8, 1'b0);
        chk("t3 err at", 64'(first_err), 64'd4);
        chk("t3 pulses", 64'(npulse), 64'd1);
        chk("t3 realign at", 64'(first_al), 64'd7);
        chk("t3 err_count", 64'(err_count), 64'd1);
        chk("t3 aligned end", 64'(aligned), 64'd1);

        // ---- Test 4: two active lanes, noise on the rest ----
        dly = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_stream(100, 10, 14, 5'd2, 1'b1);
        chk("t4 columns", 64'(ncol), 64'd10);
        chk("t4 no err", 64'(npulse), 64'd0);
        chk("t4 aligned at", 64'(first_al), 64'd1);
        chk("t4 overflow", 64'(overflow), 64'd0);
        chk("t4 upper data", out_data & 64'hFFFF_FFFF_FFFF_0000, 64'd0);
        chk("t4 upper datak", 64'(out_datak & 8'hFC), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
